// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC   = 32'h0040_0024;
    localparam logic [XLEN-1:0] EXC_VECTOR = 32'h8000_0180;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_target_sel.sv
// Picks the next fetch PC: live exception, then a parked target, then a live redirect, then pc+4.
module fetch_target_sel
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] P_EXC_VECTOR = EXC_VECTOR
) (
    input  logic            i_exception,
    input  logic            i_pend_valid,
    input  logic [XLEN-1:0] i_pend_target,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_target,
    input  logic [XLEN-1:0] i_seq_pc,
    output logic [XLEN-1:0] o_target
);

    always_comb begin
        o_target = i_seq_pc;
        if (i_exception) begin
            o_target = P_EXC_VECTOR;
        end else if (i_pend_valid) begin
            o_target = i_pend_target;
        end else if (i_redirect_valid) begin
            o_target = align_word(i_redirect_target);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC, instruction-memory request handshake and decode hand-off, with
// redirect/exception handling that also covers events arriving mid-fetch.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] P_RESET_PC   = RESET_PC,
    parameter logic [XLEN-1:0] P_EXC_VECTOR = EXC_VECTOR
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            exception,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_4,
    output logic [XLEN-1:0] pc,
    output fetch_state_t    dbg_state
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_instr_pc;
    logic [XLEN-1:0] r_pend_target;
    logic            r_pend;
    logic            r_pend_exc;

    logic            w_event;
    logic            w_ack_take;
    logic            w_capture;
    logic [XLEN-1:0] w_seq_pc;
    logic [XLEN-1:0] w_target;

    assign w_event    = exception | redirect_valid;
    assign w_ack_take = (r_state == FETCH) & imem_ack;
    assign w_capture  = w_ack_take & ~r_pend & ~w_event;
    assign w_seq_pc   = r_pc + 32'd4;

    fetch_target_sel #(
        .P_EXC_VECTOR (P_EXC_VECTOR)
    ) u_target_sel (
        .i_exception       (exception),
        .i_pend_valid      (r_pend),
        .i_pend_target     (r_pend_target),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .i_seq_pc          (w_seq_pc),
        .o_target          (w_target)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (!stall) w_state_next = FETCH;
            end
            FETCH: begin
                if (w_capture)       w_state_next = HOLD;
                else if (imem_ack)   w_state_next = stall ? IDLE : FETCH;
            end
            HOLD: begin
                if (w_event || instr_ready) w_state_next = stall ? IDLE : FETCH;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (r_state == FETCH);
        instr_valid = (r_state == HOLD);
        imem_addr   = r_pc;
        pc          = r_pc;
        instr       = r_instr;
        instr_pc    = r_instr_pc;
        instr_pc_4  = r_instr_pc + 32'd4;
        dbg_state   = r_state;
    end

    // The PC only moves on an ack; while a request is outstanding events are parked instead.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc <= P_RESET_PC;
        end else if (w_ack_take || ((r_state != FETCH) && w_event)) begin
            r_pc <= w_target;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend        <= 1'b0;
            r_pend_exc    <= 1'b0;
            r_pend_target <= '0;
        end else if (w_ack_take) begin
            r_pend     <= 1'b0;
            r_pend_exc <= 1'b0;
        end else if (r_state == FETCH) begin
            if (exception) begin
                r_pend        <= 1'b1;
                r_pend_exc    <= 1'b1;
                r_pend_target <= P_EXC_VECTOR;
            end else if (redirect_valid && !r_pend_exc) begin
                r_pend        <= 1'b1;
                r_pend_target <= align_word(redirect_target);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else if (w_capture) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= r_pc;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scenarios plus randomized traffic for fetch_sequencer, checked
// against a transaction-level model of the fetch/decode hand-off.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0040_0024;
    localparam logic [31:0] EXC_PC = 32'h8000_0180;

    logic         clock = 1'b0;
    logic         reset;
    logic         stall;
    logic         redirect_valid;
    logic [31:0]  redirect_target;
    logic         exception;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ack;
    logic [31:0]  imem_rdata;
    logic         instr_valid;
    logic         instr_ready;
    logic [31:0]  instr;
    logic [31:0]  instr_pc;
    logic [31:0]  instr_pc_4;
    logic [31:0]  pc;
    fetch_state_t dbg_state;

    int n_vec = 0;
    int n_err = 0;

    // Model: one outstanding request or one presented instruction, plus a parked target.
    logic        m_out;
    logic        m_pres;
    logic [31:0] m_pc;
    logic [31:0] m_ipc;
    logic [31:0] m_instr;
    logic [31:0] m_pt;
    int          m_pk;      // 0 none, 1 parked redirect, 2 parked exception
    logic [31:0] exp_q[$];

    bit mem_busy;
    int mem_wait;

    fetch_sequencer dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .exception       (exception),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_pc_4      (instr_pc_4),
        .pc              (pc),
        .dbg_state       (dbg_state)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out = 1'b0; m_pres = 1'b0; m_pc = RST_PC; m_ipc = '0; m_instr = '0;
        m_pt = '0; m_pk = 0; exp_q.delete(); mem_busy = 1'b0; mem_wait = 0;
    endtask

    task automatic check_all();
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_out});
        if (m_out) chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_pres});
        chk("pc", pc, m_pc);
        chk("instr", instr, m_instr);
        chk("instr_pc", instr_pc, m_ipc);
        chk("instr_pc_4", instr_pc_4, m_ipc + 32'd4);
    endtask

    task automatic expect_fetch(input string tag, input logic [31:0] addr);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        chk(tag, imem_addr, addr);
    endtask

    task automatic step(input logic st, input logic rv, input logic [31:0] rt,
                        input logic ex, input logic ak, input logic [31:0] rd,
                        input logic rdy);
        logic        evt;
        logic [31:0] tgt;
        stall = st; redirect_valid = rv; redirect_target = rt; exception = ex;
        imem_ack = ak; imem_rdata = rd; instr_ready = rdy;
        evt = ex | rv;
        tgt = ex ? EXC_PC : {rt[31:2], 2'b00};
        if (m_pres) begin
            if (exp_q.size() > 0) begin
                if (!evt && rdy) chk("sb_instr", instr, exp_q.pop_front());
                else if (evt)    void'(exp_q.pop_front());
            end
            if (evt) begin
                m_pc = tgt; m_pres = 1'b0; m_out = !st;
            end else if (rdy) begin
                m_pres = 1'b0; m_out = !st;
            end
        end else if (m_out) begin
            if (!ak) begin
                if (ex) begin
                    m_pk = 2; m_pt = EXC_PC;
                end else if (rv && m_pk != 2) begin
                    m_pk = 1; m_pt = tgt;
                end
            end else if (m_pk != 0 || evt) begin
                m_pc = ex ? EXC_PC : ((m_pk != 0) ? m_pt : tgt);
                m_pk = 0; m_out = !st;
            end else begin
                m_instr = rd; m_ipc = m_pc; m_pc = m_pc + 32'd4;
                m_out = 1'b0; m_pres = 1'b1; exp_q.push_back(rd);
            end
        end else begin
            if (evt) m_pc = tgt;
            m_out = !st;
        end
        @(posedge clock);
        @(negedge clock);
        check_all();
    endtask

    task automatic auto_step(input logic st, input logic rv, input logic [31:0] rt,
                             input logic ex, input logic rdy);
        logic ak;
        ak = 1'b0;
        if (m_out) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_wait = $urandom_range(0, 3);
            end
            if (mem_wait == 0) begin
                ak = 1'b1; mem_busy = 1'b0;
            end else begin
                mem_wait--;
            end
        end
        step(st, rv, rt, ex, ak, $urandom, rdy);
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        exception = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        model_reset();
        @(posedge clock);
        @(negedge clock);
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clock);
        do_reset();
        chk("reset_addr", imem_addr, RST_PC);
        chk("reset_pc4", instr_pc_4, 32'd4);

        // Zero-wait sequential flow.
        step(0, 0, 0, 0, 0, 0, 0);
        expect_fetch("t1_a0", 32'h0040_0024);
        step(0, 0, 0, 0, 1, 32'h1111_0001, 0);
        chk("t1_valid", {31'd0, instr_valid}, 32'd1);
        chk("t1_pc4", instr_pc_4, 32'h0040_0028);
        step(0, 0, 0, 0, 0, 0, 1);
        expect_fetch("t1_a1", 32'h0040_0028);
        step(0, 0, 0, 0, 1, 32'h1111_0002, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        expect_fetch("t1_a2", 32'h0040_002C);

        // Redirect during the first wait cycle of a slow fetch.
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h0040_0100, 0, 0, 0, 0);
        expect_fetch("t2_hold", 32'h0040_0024);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        expect_fetch("t2_hold2", 32'h0040_0024);
        step(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
        chk("t2_discard", {31'd0, instr_valid}, 32'd0);
        expect_fetch("t2_new", 32'h0040_0100);

        // Exception and redirect together while holding an instruction.
        step(0, 0, 0, 0, 1, 32'h2222_0001, 0);
        step(0, 1, 32'h0040_0200, 1, 0, 0, 0);
        chk("t3_flush", {31'd0, instr_valid}, 32'd0);
        expect_fetch("t3_exc", EXC_PC);

        // Parked exception is not displaced by a later redirect.
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 32'h0040_0300, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h3333_0001, 0);
        expect_fetch("t4_exc", EXC_PC);

        // Stall after hand-off.
        step(0, 0, 0, 0, 1, 32'h4444_0001, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        chk("t5_noreq0", {31'd0, imem_req}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            chk("t5_noreq", {31'd0, imem_req}, 32'd0);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        expect_fetch("t5_resume", 32'h8000_0184);

        // Unaligned redirect near the top of memory, then wrap.
        step(0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h5555_0001, 0);
        expect_fetch("t6_top", 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 1, 32'h5555_0002, 0);
        chk("t6_pc4", instr_pc_4, 32'h0000_0000);
        step(0, 0, 0, 0, 0, 0, 1);
        expect_fetch("t6_wrap", 32'h0000_0000);

        // Asynchronous reset mid-fetch, then a late ack in IDLE.
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("t7_req", {31'd0, imem_req}, 32'd0);
        chk("t7_valid", {31'd0, instr_valid}, 32'd0);
        chk("t7_pc", pc, RST_PC);
        chk("t7_addr", imem_addr, RST_PC);
        chk("t7_pc4", instr_pc_4, 32'd4);
        chk("t7_instr", instr, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        step(1, 0, 0, 0, 1, 32'h6666_0001, 0);
        chk("t7_late_ack", {31'd0, instr_valid}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        expect_fetch("t7_restart", RST_PC);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            auto_step($urandom_range(0, 3) == 0,
                      $urandom_range(0, 9) == 0,
                      $urandom,
                      $urandom_range(0, 29) == 0,
                      $urandom_range(0, 2) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controls the program counter of the CPU core and the instruction-memory fetch handshake. Holds the fetch PC (reset vector 0x00400024), issues one request per instruction to instruction memory, and presents the fetched word with its PC and PC+4 to decode. It also applies branch/jump redirects and exception vectoring, including redirects that arrive while a fetch is still outstanding.

## Interface
- RESET_PC, 32'h00400024, fetch PC after reset
- EXC_VECTOR, 32'h80000180, target on exception
- clock  in  1  system clock, posedge
- reset  in  1  asynchronous, active-high
- stall  in  1  blocks launching a new fetch
- redirect_valid  in  1  branch/jump taken, one-cycle pulse
- redirect_target  in  32  redirect address; bits [1:0] forced to 0
- exception  in  1  exception pulse; outranks redirect
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_ack  in  1  data valid on imem_rdata this cycle
- imem_rdata  in  32  instruction word
- instr_valid  out  1  instruction available to decode
- instr_ready  in  1  decode accepts instruction
- instr  out  32  instruction word
- instr_pc  out  32  PC of instr
- instr_pc_4  out  32  instr_pc + 4, mod 2^32
- pc  out  32  current fetch PC

## Operation
- States:
  - IDLE: no request outstanding.
  - FETCH: request outstanding.
  - HOLD: instruction presented to decode.
- Target priority: exception (EXC_VECTOR) > redirect_valid (redirect_target) > sequential (pc+4).
- IDLE: if stall=0, go to FETCH. Otherwise stay.
- FETCH:
  - Drive imem_req=1 and imem_addr=pc.
  - imem_addr is held stable until imem_ack.
- FETCH, redirect or exception without ack:
  - Latch the target into the pending register with pend=1.
  - A later exception overwrites a pending redirect.
  - A later redirect does not overwrite a pending exception.
- FETCH, imem_ack with pend=0 and no event this cycle:
  - Capture instr=imem_rdata and instr_pc=pc.
  - Set pc<=pc+4 and go to HOLD.
- FETCH, imem_ack with pend=1 or an event this cycle:
  - Discard the data.
  - Set pc<=highest-priority target and clear pend.
  - Go to FETCH if stall=0, else IDLE.
- HOLD: instr_valid=1, outputs stable.
  - On instr_ready: go to FETCH if stall=0, else IDLE.
- Redirect or exception in IDLE or HOLD:
  - Set pc<=target.
  - HOLD drops instr_valid next cycle (flush), regardless of instr_ready.
  - Next state is FETCH if stall=0, else IDLE.
- Arithmetic: pc+4 wraps, so 0xFFFFFFFC -> 0x00000000.
- Reset (async, any state, including mid-fetch):
  - state=IDLE, pc=imem_addr=RESET_PC.
  - imem_req=0, instr_valid=0, instr=instr_pc=0, pend=0.
  - instr_pc_4 therefore resets to 4.
  - A late imem_ack after reset, in IDLE, is ignored.

## Timing
- All state, pc and outputs are registered. instr_pc_4 is combinational from instr_pc.
- Zero-wait memory: FETCH entered at cycle N, ack at N. instr_valid=1 at N+1.
- Peak throughput is one instruction per 2 cycles (FETCH, HOLD).
- A redirect in cycle N updates pc at N+1. The first request to the new target is at N+1 when stall=0 in cycle N.
- Redirect during an outstanding fetch: the request to the new target appears the cycle after the ack.
- First request after reset release: 2 cycles later (IDLE, then FETCH), with stall=0.

## Structure
- Package fetch_pkg holds:
  - state enum {IDLE, FETCH, HOLD}
  - default RESET_PC and EXC_VECTOR constants
  - instruction word width constant
- Sub-module fetch_target_sel: combinational priority select of exception/pending/redirect/sequential target, with alignment masking.
- All registers and the FSM live in fetch_sequencer.

## Test plan
- Reset release, stall=0, ack in the same cycle as req:
  - imem_addr sequence is 0x00400024, 0x00400028, 0x0040002C.
  - instr_pc_4 of the first instruction is 0x00400028.
- Memory with 3 wait cycles; redirect_target=0x00400100 during the first wait cycle:
  - imem_addr stays 0x00400024 until ack.
  - That data is discarded: instr_valid stays 0.
  - The next request is to 0x00400100.
- In HOLD with instr_ready=0, exception and redirect (0x00400200) in the same cycle:
  - instr_valid drops next cycle.
  - The next fetch is 0x80000180.
- Pending exception during a wait, then a redirect to 0x00400300 before ack:
  - The fetch after ack goes to 0x80000180.
- stall=1 held for 4 cycles in HOLD after instr_ready:
  - No imem_req during the stall.
  - The fetch resumes at pc+4 the cycle after stall falls.
- Redirect to 0xFFFFFFFE then sequential flow:
  - Addresses are 0xFFFFFFFC, then 0x00000000.
- Reset asserted mid-fetch:
  - Outputs immediately take reset values.
  - A late ack is ignored.
